hazard_sequencer: RTL and testbench
===================================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- NUM_REGS, 16, architectural registers tracked.
- CNT_W, 2, pending-write counter width per register.
- PERF_W, 16, stall performance counter width.

REQ-002 Ports, one per line (name, direction, width, meaning); clock and reset first:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, asynchronous, active-low reset.
- id_valid, in, 1, ID stage holds a valid instruction.
- id_src1, in, 4, Rn index.
- id_src2, in, 4, Rm or Rd-for-store index.
- id_two_src, in, 1, src2 is read.
- id_wb_en, in, 1, ID instruction writes a register.
- id_dest, in, 4, ID destination index.
- wb_commit, in, 1, one-cycle pulse per register writeback.
- wb_dest, in, 4, writeback index.
- exe_branch_taken, in, 1, branch resolved taken in EXE.
- mem_req, in, 1, MEM stage has a load or store in flight.
- mem_ready, in, 1, data memory completes this cycle.
- hazard, out, 1, to ID: zero control signals, do not issue.
- freeze_pc, out, 1, hold PC.
- freeze_ifid, out, 1, hold IF/ID register.
- freeze_all, out, 1, hold every pipeline register.
- flush, out, 1, kill IF/ID contents.
- stall_cycles, out, PERF_W, saturating count of cycles with hazard or freeze_all.

Function
REQ-003 The block SHALL keep, per register, a CNT_W-bit count of issued-but-uncommitted writes.
REQ-004 An issue event SHALL be id_valid & id_wb_en & ~hazard & ~freeze_all & ~flush; it increments count[id_dest] at the clock edge.
REQ-005 A retire event SHALL be wb_commit & ~freeze_all; it decrements count[wb_dest].
REQ-006 Issue and retire to the same register in the same cycle SHALL leave the count unchanged.
REQ-007 Retire of a register whose count is 0 SHALL leave it at 0 and set the sticky status bit sb_underflow (internal, visible in simulation).
REQ-008 hazard SHALL be combinational and equal id_valid & (count[id_src1]!=0 | (id_two_src & count[id_src2]!=0) | (id_wb_en & count[id_dest]==max)), forced to 1 whenever freeze_all=1.
REQ-009 FSM states SHALL be RUN, STALL_MEM, FLUSH. Priority when several conditions hold: STALL_MEM > FLUSH > dependency stall.
REQ-010 RUN -> STALL_MEM when mem_req & ~mem_ready. STALL_MEM holds while mem_ready=0 and exits on the edge where mem_ready=1.
REQ-011 freeze_all SHALL be 1 in the cycle mem_req & ~mem_ready is seen and in every STALL_MEM cycle until mem_ready=1. It is 0 in the mem_ready cycle, so completion takes 0 extra cycles.
REQ-012 A branch taken outside a stall: flush=1 in that same cycle, FSM enters FLUSH for exactly 1 cycle, with flush=1 and hazard=1, then returns to RUN.
REQ-013 exe_branch_taken during a stall SHALL be latched. The flush then occurs in the first cycle after the stall ends.
REQ-014 freeze_pc and freeze_ifid SHALL equal (hazard & ~flush) | freeze_all.
REQ-015 stall_cycles SHALL increment once per cycle where hazard|freeze_all, and saturate at all-ones.

Reset
REQ-016 Asserting rst=0 SHALL asynchronously clear all counts, the latched branch, sb_underflow and stall_cycles, and put the FSM in RUN.
REQ-017 While in reset, every output SHALL be 0.
REQ-018 Reset asserted mid-stall or mid-flush SHALL abandon the operation, with no residual freeze after release.

Structure
REQ-019 A shared package hz_pkg SHALL hold the FSM state enum, NUM_REGS, CNT_W and the register-index type.
REQ-020 The per-register counters and the lookup logic SHALL live in one sub-module, hz_scoreboard, instantiated once.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- RAW stall: issue wb r3, next cycle src1=3 -> hazard=1 until the wb_commit r3 cycle, then 0 in the next cycle.
- Same-cycle issue and retire of r5 with count 1 -> count stays 1, hazard for src1=5 remains 1.
- Saturation: three issues to r7, fourth instruction with dest=7 -> hazard=1, no increment.
- Memory stall: mem_req=1, mem_ready=0 for 3 cycles -> freeze_all=1 for 3 cycles, stall_cycles=3, no count changes.
- Branch during stall: exe_branch_taken pulse while freeze_all=1 -> flush=1 in the first cycle after mem_ready=1.
- Reset mid-STALL_MEM -> outputs 0 immediately, counts 0 after release.

Source files
------------

// File: rtl/hz_pkg.sv
// Shared types and sizing for the hazard sequencer: register-file geometry,
// register-index type and the sequencer FSM state encoding.
package hz_pkg;

    localparam int NUM_REGS  = 16;
    localparam int CNT_W     = 2;
    localparam int REG_IDX_W = $clog2(NUM_REGS);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        STALL_MEM = 2'd1,
        FLUSH     = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_sequencer_if.sv
// Pipeline-to-sequencer bundle: ID/WB/EXE/MEM status in, stall/flush controls out.
interface hazard_sequencer_if #(
    parameter int PERF_W = 16
);

    logic              id_valid;
    hz_pkg::reg_idx_t  id_src1;
    hz_pkg::reg_idx_t  id_src2;
    logic              id_two_src;
    logic              id_wb_en;
    hz_pkg::reg_idx_t  id_dest;
    logic              wb_commit;
    hz_pkg::reg_idx_t  wb_dest;
    logic              exe_branch_taken;
    // mem_req/mem_ready: a memory access is in flight while mem_req=1 and
    // completes in the cycle where mem_ready=1; mem_req stays high until then.
    logic              mem_req;
    logic              mem_ready;

    logic              hazard;
    logic              freeze_pc;
    logic              freeze_ifid;
    logic              freeze_all;
    logic              flush;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest,
        output wb_commit, wb_dest, exe_branch_taken, mem_req, mem_ready,
        input  hazard, freeze_pc, freeze_ifid, freeze_all, flush, stall_cycles
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest,
        input  wb_commit, wb_dest, exe_branch_taken, mem_req, mem_ready,
        output hazard, freeze_pc, freeze_ifid, freeze_all, flush, stall_cycles
    );

endinterface

// File: rtl/hz_scoreboard.sv
// Per-register pending-write counters plus the source/destination lookups
// the sequencer uses to detect dependency hazards.
module hz_scoreboard
    import hz_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  reg_idx_t src1_i,
    input  reg_idx_t src2_i,
    input  reg_idx_t dest_i,
    input  logic     issue_i,
    input  logic     retire_i,
    input  reg_idx_t retire_dest_i,
    output logic     src1_busy_o,
    output logic     src2_busy_o,
    output logic     dest_full_o,
    output logic     underflow_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic                underflow_q;
    logic                underflow_d;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_vec[i] = issue_i  & (dest_i        == reg_idx_t'(i));
            dec_vec[i] = retire_i & (retire_dest_i == reg_idx_t'(i));
        end
    end

    // A simultaneous issue and retire on one register cancel out.
    always_comb begin
        underflow_d = underflow_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (cnt_q[i] == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    assign src1_busy_o = (cnt_q[src1_i] != '0);
    assign src2_busy_o = (cnt_q[src2_i] != '0);
    assign dest_full_o = (cnt_q[dest_i] == CNT_MAX);
    assign underflow_o = underflow_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: dependency stalls from the scoreboard, memory
// wait freezes and branch flushes, with a saturating stall-cycle counter.
module hazard_sequencer
    import hz_pkg::*;
#(
    parameter int PERF_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_sequencer_if.slave    bus,
    output hz_state_e            dbg_state_o,
    output logic                 dbg_underflow_o
);

    hz_state_e         state_q;
    logic              br_pend_q;
    logic [PERF_W-1:0] stall_cnt_q;

    logic mem_wait;
    logic freeze_raw;
    logic in_flush;
    logic src1_busy;
    logic src2_busy;
    logic dest_full;
    logic dep_hazard;
    logic hazard_raw;
    logic flush_raw;
    logic freeze_fe_raw;
    logic issue;
    logic retire;
    logic underflow;

    assign mem_wait   = bus.mem_req & ~bus.mem_ready;
    assign freeze_raw = (state_q == STALL_MEM) ? ~bus.mem_ready : mem_wait;
    assign in_flush   = (state_q == FLUSH);

    assign dep_hazard = bus.id_valid & (src1_busy
                                      | (bus.id_two_src & src2_busy)
                                      | (bus.id_wb_en & dest_full));
    assign hazard_raw = freeze_raw | in_flush | dep_hazard;

    // A memory freeze outranks any flush; branches seen under a freeze are
    // replayed through the FLUSH state once the freeze lifts.
    assign flush_raw     = ~freeze_raw & (((state_q == RUN) & bus.exe_branch_taken) | in_flush);
    assign freeze_fe_raw = (hazard_raw & ~flush_raw) | freeze_raw;

    assign issue  = bus.id_valid & bus.id_wb_en & ~hazard_raw & ~freeze_raw & ~flush_raw;
    assign retire = bus.wb_commit & ~freeze_raw;

    hz_scoreboard u_scoreboard (
        .clk           (clk),
        .rst_n         (rst),
        .src1_i        (bus.id_src1),
        .src2_i        (bus.id_src2),
        .dest_i        (bus.id_dest),
        .issue_i       (issue),
        .retire_i      (retire),
        .retire_dest_i (bus.wb_dest),
        .src1_busy_o   (src1_busy),
        .src2_busy_o   (src2_busy),
        .dest_full_o   (dest_full),
        .underflow_o   (underflow)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            br_pend_q <= 1'b0;
        end else begin
            case (state_q)
                RUN, FLUSH: begin
                    if (mem_wait) begin
                        state_q   <= STALL_MEM;
                        br_pend_q <= bus.exe_branch_taken | in_flush;
                    end else if (bus.exe_branch_taken) begin
                        state_q   <= FLUSH;
                        br_pend_q <= 1'b0;
                    end else begin
                        state_q   <= RUN;
                        br_pend_q <= 1'b0;
                    end
                end
                STALL_MEM: begin
                    if (bus.mem_ready) begin
                        state_q   <= (br_pend_q | bus.exe_branch_taken) ? FLUSH : RUN;
                        br_pend_q <= 1'b0;
                    end else begin
                        br_pend_q <= br_pend_q | bus.exe_branch_taken;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    br_pend_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (hazard_raw && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    // Reset gates the combinational controls so nothing leaks while rst=0.
    assign bus.hazard       = rst & hazard_raw;
    assign bus.freeze_all   = rst & freeze_raw;
    assign bus.flush        = rst & flush_raw;
    assign bus.freeze_pc    = rst & freeze_fe_raw;
    assign bus.freeze_ifid  = rst & freeze_fe_raw;
    assign bus.stall_cycles = stall_cnt_q;

    assign dbg_state_o     = state_q;
    assign dbg_underflow_o = underflow;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: RAW, same-cycle issue/retire,
// saturation, memory stall, branch replay and reset-abort scenarios.
module tb_hazard_sequencer;
    import hz_pkg::*;

    localparam int PERF_W = 16;

    logic      clk;
    logic      rst;
    hz_state_e dbg_state;
    logic      dbg_underflow;
    int        n_vec;
    int        n_err;

    hazard_sequencer_if #(.PERF_W(PERF_W)) bus ();

    hazard_sequencer #(.PERF_W(PERF_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .dbg_state_o     (dbg_state),
        .dbg_underflow_o (dbg_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic id_op(input logic v, input logic wb, input logic [3:0] dst,
                         input logic [3:0] s1, input logic two, input logic [3:0] s2);
        bus.id_valid   = v;
        bus.id_wb_en   = wb;
        bus.id_dest    = dst;
        bus.id_src1    = s1;
        bus.id_two_src = two;
        bus.id_src2    = s2;
    endtask

    task automatic wb_op(input logic c, input logic [3:0] d);
        bus.wb_commit = c;
        bus.wb_dest   = d;
    endtask

    task automatic mem_op(input logic req, input logic rdy);
        bus.mem_req   = req;
        bus.mem_ready = rdy;
    endtask

    task automatic idle();
        id_op(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0);
        wb_op(1'b0, 4'd0);
        mem_op(1'b0, 1'b0);
        bus.exe_branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        idle();
        // Outputs must stay low in reset even with every request active.
        bus.mem_req          = 1'b1;
        bus.id_valid         = 1'b1;
        bus.id_wb_en         = 1'b1;
        bus.exe_branch_taken = 1'b1;
        bus.wb_commit        = 1'b1;
        #2;
        chk("rst_hazard", bus.hazard, 0);
        chk("rst_freeze_all", bus.freeze_all, 0);
        chk("rst_flush", bus.flush, 0);
        chk("rst_freeze_pc", bus.freeze_pc, 0);
        chk("rst_freeze_ifid", bus.freeze_ifid, 0);
        chk("rst_stall_cycles", bus.stall_cycles, 0);
        chk("rst_state", dbg_state, RUN);
        repeat (2) @(negedge clk);
        idle();
        rst = 1'b1;

        // RAW stall on r3, then a src2-only dependency on r8.
        @(negedge clk); id_op(1, 1, 3, 0, 0, 0); #1;
        chk("raw_issue_hz", bus.hazard, 0);
        @(negedge clk); id_op(1, 0, 0, 3, 0, 0); #1;
        chk("raw_stall_c1", bus.hazard, 1);
        chk("raw_freeze_pc", bus.freeze_pc, 1);
        chk("raw_freeze_ifid", bus.freeze_ifid, 1);
        @(negedge clk); #1;
        chk("raw_stall_c2", bus.hazard, 1);
        @(negedge clk); wb_op(1, 3); #1;
        chk("raw_commit_cyc", bus.hazard, 1);
        @(negedge clk); wb_op(0, 0); #1;
        chk("raw_clear", bus.hazard, 0);
        chk("raw_stall_cnt", bus.stall_cycles, 3);
        @(negedge clk); id_op(1, 1, 8, 0, 0, 0); #1;
        chk("src2_issue_hz", bus.hazard, 0);
        @(negedge clk); id_op(1, 0, 0, 1, 1, 8); #1;
        chk("src2_dep_hz", bus.hazard, 1);
        @(negedge clk); id_op(1, 0, 0, 1, 0, 8); #1;
        chk("src2_unused_hz", bus.hazard, 0);

        // Same-cycle issue and retire of r5 with count 1.
        do_reset();
        @(negedge clk); id_op(1, 1, 5, 0, 0, 0); #1;
        chk("same_first_hz", bus.hazard, 0);
        @(negedge clk); id_op(1, 1, 5, 0, 0, 0); wb_op(1, 5); #1;
        chk("same_cyc_hz", bus.hazard, 0);
        @(negedge clk); id_op(1, 0, 0, 5, 0, 0); wb_op(0, 0); #1;
        chk("same_cnt_kept", bus.hazard, 1);
        @(negedge clk); id_op(0, 0, 0, 0, 0, 0); wb_op(1, 5);
        @(negedge clk); id_op(1, 0, 0, 5, 0, 0); wb_op(0, 0); #1;
        chk("same_cnt_one", bus.hazard, 0);
        chk("same_no_uflow", dbg_underflow, 0);

        // Saturation of r7, then underflow on an idle register.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); id_op(1, 1, 7, 0, 0, 0); #1;
            chk("sat_issue", bus.hazard, 0);
        end
        @(negedge clk); id_op(1, 1, 7, 0, 0, 0); #1;
        chk("sat_full_hz", bus.hazard, 1);
        chk("sat_full_fpc", bus.freeze_pc, 1);
        @(negedge clk); id_op(0, 0, 0, 0, 0, 0); wb_op(1, 7);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); wb_op(0, 0); id_op(1, 0, 0, 7, 0, 0); #1;
        chk("sat_no_wrap", bus.hazard, 0);
        chk("sat_no_uflow", dbg_underflow, 0);
        @(negedge clk); id_op(0, 0, 0, 0, 0, 0); wb_op(1, 9);
        @(negedge clk); wb_op(0, 0); id_op(1, 0, 0, 9, 0, 0); #1;
        chk("uflow_set", dbg_underflow, 1);
        chk("uflow_cnt0", bus.hazard, 0);

        // Memory stall: three frozen cycles, blocked issue and retire.
        do_reset();
        @(negedge clk); mem_op(1, 0); id_op(1, 1, 2, 0, 0, 0); wb_op(1, 4); #1;
        chk("mem_c1_fa", bus.freeze_all, 1);
        chk("mem_c1_hz", bus.hazard, 1);
        chk("mem_c1_fpc", bus.freeze_pc, 1);
        chk("mem_c1_flush", bus.flush, 0);
        @(negedge clk); #1;
        chk("mem_c2_fa", bus.freeze_all, 1);
        chk("mem_c2_state", dbg_state, STALL_MEM);
        @(negedge clk); #1;
        chk("mem_c3_fa", bus.freeze_all, 1);
        @(negedge clk); mem_op(1, 1); id_op(0, 0, 0, 0, 0, 0); wb_op(0, 0); #1;
        chk("mem_rdy_fa", bus.freeze_all, 0);
        chk("mem_rdy_hz", bus.hazard, 0);
        chk("mem_stall_cnt", bus.stall_cycles, 3);
        @(negedge clk); mem_op(0, 0); id_op(1, 0, 0, 2, 0, 0); #1;
        chk("mem_end_state", dbg_state, RUN);
        chk("mem_no_issue", bus.hazard, 0);
        chk("mem_no_retire", dbg_underflow, 0);
        chk("mem_cnt_hold", bus.stall_cycles, 3);

        // Branch latched during a stall, then a branch in RUN.
        do_reset();
        @(negedge clk); mem_op(1, 0); #1;
        chk("br_c1_fa", bus.freeze_all, 1);
        @(negedge clk); bus.exe_branch_taken = 1'b1; #1;
        chk("br_stall_flush", bus.flush, 0);
        chk("br_stall_fa", bus.freeze_all, 1);
        @(negedge clk); bus.exe_branch_taken = 1'b0; mem_op(1, 1); #1;
        chk("br_rdy_fa", bus.freeze_all, 0);
        chk("br_rdy_flush", bus.flush, 0);
        @(negedge clk); mem_op(0, 0); #1;
        chk("br_late_flush", bus.flush, 1);
        chk("br_late_hz", bus.hazard, 1);
        chk("br_late_fpc", bus.freeze_pc, 0);
        chk("br_late_state", dbg_state, FLUSH);
        @(negedge clk); #1;
        chk("br_late_done", bus.flush, 0);
        chk("br_late_hz0", bus.hazard, 0);
        chk("br_late_run", dbg_state, RUN);
        @(negedge clk); bus.exe_branch_taken = 1'b1; #1;
        chk("br_run_flush", bus.flush, 1);
        chk("br_run_state", dbg_state, RUN);
        @(negedge clk); bus.exe_branch_taken = 1'b0; #1;
        chk("br_flush_state", dbg_state, FLUSH);
        chk("br_flush_out", bus.flush, 1);
        chk("br_flush_hz", bus.hazard, 1);
        @(negedge clk); #1;
        chk("br_back_run", dbg_state, RUN);
        chk("br_back_flush", bus.flush, 0);

        // Reset asserted in the middle of STALL_MEM.
        do_reset();
        @(negedge clk); id_op(1, 1, 6, 0, 0, 0); #1;
        chk("rs_issue_hz", bus.hazard, 0);
        @(negedge clk); id_op(0, 0, 0, 0, 0, 0); mem_op(1, 0);
        @(negedge clk); #1;
        chk("rs_state", dbg_state, STALL_MEM);
        chk("rs_fa_before", bus.freeze_all, 1);
        #1; rst = 1'b0; #1;
        chk("rs_fa", bus.freeze_all, 0);
        chk("rs_hz", bus.hazard, 0);
        chk("rs_fpc", bus.freeze_pc, 0);
        chk("rs_flush", bus.flush, 0);
        chk("rs_stall_cnt", bus.stall_cycles, 0);
        chk("rs_state_run", dbg_state, RUN);
        @(negedge clk); mem_op(0, 0); rst = 1'b1;
        @(negedge clk); id_op(1, 0, 0, 6, 0, 0); #1;
        chk("rs_cnt_clear", bus.hazard, 0);
        chk("rs_no_freeze", bus.freeze_all, 0);
        chk("rs_after_state", dbg_state, RUN);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
